data_memory_sized: RTL and testbench

Parametrised byte-addressable data memory for the unicycle/pipelined cores. It replaces the single-bit byte-enable memory with sized accesses (byte/half/word/dword), sign or zero extension on loads, and alignment and range checking. Requests enter through a valid/ready handshake. Responses leave a fixed-latency read pipeline tagged valid/err. It sits between the core's memory stage and the backing RAM array.

---
 rtl/data_memory_pkg.sv | 57 +++++
 rtl/data_memory_array.sv | 33 +++
 rtl/data_memory_sized.sv | 147 ++++++++++++++
 tb/tb_data_memory_sized.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the sized data memory.
// Widths are sized for the 64-bit build; 32-bit builds truncate.
package data_memory_pkg;

   localparam int MAX_DW    = 64;
   localparam int MAX_LANES = 8;

   typedef enum logic [1:0] {
      SIZE_BYTE  = 2'd0,
      SIZE_HALF  = 2'd1,
      SIZE_WORD  = 2'd2,
      SIZE_DWORD = 2'd3
   } size_e;

   typedef struct packed {
      logic              valid;
      logic              we;
      size_e             size;
      logic              uns;
      logic [2:0]        offset;
      logic              err;
      logic [MAX_DW-1:0] raw;
   } stage_t;

   function automatic logic [MAX_LANES-1:0] lane_mask(
      input size_e      size,
      input logic [2:0] offset
   );
      logic [MAX_LANES-1:0] m;
      unique case (size)
         SIZE_BYTE: m = 8'h01;
         SIZE_HALF: m = 8'h03;
         SIZE_WORD: m = 8'h0f;
         default:   m = 8'hff;
      endcase
      return m << offset;
   endfunction

   function automatic logic [MAX_DW-1:0] extend(
      input logic [MAX_DW-1:0] raw,
      input size_e             size,
      input logic [2:0]        offset,
      input logic              uns
   );
      logic [MAX_DW-1:0] s;
      logic [MAX_DW-1:0] r;
      s = raw >> {offset, 3'b000};
      unique case (size)
         SIZE_BYTE: r = {{56{~uns & s[7]}}, s[7:0]};
         SIZE_HALF: r = {{48{~uns & s[15]}}, s[15:0]};
         SIZE_WORD: r = {{32{~uns & s[31]}}, s[31:0]};
         default:   r = s;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/data_memory_array.sv
// Byte-lane RAM: per-lane write enable, read-first registered read.
// Optional init image parameter retained for interface compatibility.
module data_memory_array #(
  parameter int    LANES     = 4,
  parameter int    DEPTH     = 256,
  parameter int    IDX_W     = 8,
  parameter string INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               en,
  input  logic [LANES-1:0]   wmask,
  input  logic [IDX_W-1:0]   idx,
  input  logic [LANES*8-1:0] wdata,
  output logic [LANES*8-1:0] rdata
);

  logic [LANES*8-1:0] mem_q [DEPTH];
  logic [LANES*8-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[idx];
    end
    for (int l = 0; l < LANES; l++) begin
      if (wmask[l]) begin
        mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_sized.sv
// Sized data memory: request checker, fixed-latency read pipeline
// and load formatter around a byte-lane RAM.
module data_memory_sized #(
   parameter int    DATA_WIDTH    = 32,
   parameter int    ADDRESS_WIDTH = 32,
   parameter int    MEM_SIZE      = 1024,
   parameter int    READ_LATENCY  = 1,
   parameter string INIT_FILE     = ""
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [1:0]               req_size,
   input  logic                     req_unsigned,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   output logic                     rsp_valid,
   output logic [DATA_WIDTH-1:0]    rsp_rdata,
   output logic                     rsp_err
);

   import data_memory_pkg::*;

   localparam int LANES = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(LANES);
   localparam int DEPTH = MEM_SIZE / LANES;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AW1   = ADDRESS_WIDTH + 1;

   generate
      if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
         $error("DATA_WIDTH must be 32 or 64");
      end
      if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
         $error("READ_LATENCY must be 1..4");
      end
      if (MEM_SIZE % LANES != 0) begin : g_bad_size
         $error("MEM_SIZE must be a multiple of LANES");
      end
   endgenerate

   logic                  accept;
   size_e                 size;
   logic [AW1-1:0]        nbytes;
   logic [AW1-1:0]        end_addr;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  illegal;
   logic                  err;
   logic [2:0]            offset;
   logic [MAX_LANES-1:0]  full_mask;
   logic [LANES-1:0]      wmask;
   logic [DATA_WIDTH-1:0] wdata_sh;
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] arr_rdata;

   assign req_ready = !rst;

   always_comb begin
      accept       = req_valid && !rst;
      size         = size_e'(req_size);
      nbytes       = AW1'(4'b0001 << req_size);
      end_addr     = {1'b0, req_addr} + nbytes;
      // nbytes[2:0] wraps to 0 for dwords, so the mask becomes 7
      misaligned   = |(req_addr[2:0] & (nbytes[2:0] - 3'd1));
      out_of_range = end_addr > AW1'(MEM_SIZE);
      illegal      = (DATA_WIDTH == 32) && (req_size == 2'd3);
      err          = misaligned | out_of_range | illegal;
      offset       = '0;
      offset[OFF_W-1:0] = req_addr[OFF_W-1:0];
      full_mask    = lane_mask(size, offset);
      wmask        = full_mask[LANES-1:0]
                   & {LANES{accept & req_we & !err}};
      wdata_sh     = req_wdata << {offset, 3'b000};
      idx          = req_addr[OFF_W +: IDX_W];
   end

   data_memory_array #(
      .LANES     (LANES),
      .DEPTH     (DEPTH),
      .IDX_W     (IDX_W),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk   (clk),
      .en    (accept),
      .wmask (wmask),
      .idx   (idx),
      .wdata (wdata_sh),
      .rdata (arr_rdata)
   );

   stage_t                pipe_q [READ_LATENCY];
   stage_t                pipe_d [READ_LATENCY];
   stage_t                cur    [READ_LATENCY];
   stage_t                last;
   logic [MAX_DW-1:0]     fmt;
   logic                  rsp_valid_d, rsp_valid_q;
   logic                  rsp_err_d, rsp_err_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_d, rsp_rdata_q;

   always_comb begin
      cur        = pipe_q;
      // stage 0 raw word is the array's registered read port
      cur[0].raw = MAX_DW'(arr_rdata);
      pipe_d[0]  = '{valid:  accept,
                     we:     req_we,
                     size:   size,
                     uns:    req_unsigned,
                     offset: offset,
                     err:    err,
                     raw:    '0};
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_d[i] = cur[i-1];
      end
      last        = cur[READ_LATENCY-1];
      fmt         = extend(last.raw, last.size, last.offset, last.uns);
      rsp_valid_d = last.valid;
      rsp_err_d   = last.valid & last.err;
      rsp_rdata_d = '0;
      if (last.valid && !last.we && !last.err) begin
         rsp_rdata_d = fmt[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_q[i].valid <= 1'b0;
         end
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         pipe_q      <= pipe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized (32-bit, 1 KiB, latency 3).
`timescale 1ns/1ps
module tb_data_memory_sized;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int MS  = 1024;
   localparam int RL  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [1:0]    req_size = 2'd0;
   logic          req_unsigned = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;

   data_memory_sized #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .MEM_SIZE      (MS),
      .READ_LATENCY  (RL),
      .INIT_FILE     ("")
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] d;
      logic        e;
   } exp_t;

   exp_t       q[$];
   logic [7:0] mem_m [MS];
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic model(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] rd, output logic e);
      int nb;
      nb = 1 << sz;
      e  = (sz == 2'd3) || (a % nb != 0)
        || (longint'(a) + nb > MS);
      rd = '0;
      if (!e) begin
         if (we) begin
            for (int b = 0; b < nb; b++) mem_m[a+b] = wd[8*b +: 8];
         end else begin
            for (int b = 0; b < nb; b++) rd[8*b +: 8] = mem_m[a+b];
            if (!uns && nb < 4 && rd[8*nb-1]) begin
               for (int b = nb; b < 4; b++) rd[8*b +: 8] = 8'hff;
            end
         end
      end
   endtask

   task automatic issue(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd);
      exp_t x;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      model(we, sz, uns, a, wd, x.d, x.e);
      x.due = cyc + 1 + RL;
      q.push_back(x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (!rst) begin
         if (q.size() > 0 && q[0].due < cyc) begin
            check("rsp_late", 64'(cyc), 64'(q[0].due));
            void'(q.pop_front());
         end
         if (rsp_valid) begin
            if (q.size() == 0) begin
               check("rsp_spurious", 64'(rsp_valid), 64'd0);
            end else begin
               x = q.pop_front();
               check("rsp_cycle", 64'(cyc), 64'(x.due));
               check("rsp_rdata", 64'(rsp_rdata), 64'(x.d));
               check("rsp_err", 64'(rsp_err), 64'(x.e));
            end
         end
      end
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < MS; i++) mem_m[i] = 8'h00;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_valid", 64'(rsp_valid), 64'd0);
         check("rst_rdata", 64'(rsp_rdata), 64'd0);
         check("rst_err", 64'(rsp_err), 64'd0);
         check("rst_ready", 64'(req_ready), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("ready", 64'(req_ready), 64'd1);

      issue(1, 2, 0, 32'h18, 32'hb6a84325);
      issue(0, 2, 0, 32'h18, 32'h0);
      issue(1, 0, 0, 32'h19, 32'h00000074);
      issue(0, 2, 0, 32'h18, 32'h0);
      issue(0, 0, 1, 32'h19, 32'h0);
      issue(0, 0, 0, 32'h1b, 32'h0);
      issue(0, 0, 1, 32'h1b, 32'h0);
      issue(0, 1, 0, 32'h1a, 32'h0);
      issue(0, 1, 1, 32'h1a, 32'h0);
      issue(1, 1, 0, 32'h19, 32'hffffffff);
      issue(0, 2, 0, 32'h18, 32'h0);
      issue(0, 2, 0, 32'h400, 32'h0);
      issue(1, 2, 0, 32'h3fc, 32'h11223344);
      issue(0, 2, 0, 32'h3fc, 32'h0);
      issue(0, 0, 0, 32'h3ff, 32'h0);
      issue(0, 1, 1, 32'h3fe, 32'h0);
      issue(0, 1, 0, 32'h3ff, 32'h0);
      issue(0, 3, 0, 32'h0, 32'h0);
      issue(1, 2, 0, 32'h3fe, 32'h55555555);
      issue(1, 3, 0, 32'h18, 32'h0);
      idle(2);

      issue(1, 2, 0, 32'h0, 32'h01020304);
      issue(1, 2, 0, 32'h4, 32'h8899aabb);
      issue(1, 2, 0, 32'h8, 32'hcafef00d);
      issue(0, 2, 0, 32'h0, 32'h0);
      issue(0, 2, 0, 32'h4, 32'h0);
      issue(0, 2, 0, 32'h8, 32'h0);
      issue(1, 2, 0, 32'h0, 32'h0badf00d);
      issue(0, 2, 0, 32'h0, 32'h0);
      idle(RL + 2);

      issue(0, 2, 0, 32'h18, 32'h0);
      issue(0, 2, 0, 32'h4, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h18;
      req_wdata = 32'hdeadbeef;
      for (int i = 0; i < RL + 1; i++) begin
         @(negedge clk);
         check("midrst_valid", 64'(rsp_valid), 64'd0);
         check("midrst_rdata", 64'(rsp_rdata), 64'd0);
         check("midrst_err", 64'(rsp_err), 64'd0);
      end
      rst = 1'b0;
      req_valid = 1'b0;
      issue(0, 2, 0, 32'h18, 32'h0);
      issue(0, 2, 0, 32'h8, 32'h0);
      idle(RL + 2);

      for (int a = 0; a < 64; a += 4) begin
         issue(1, 2, 0, 32'(a), $urandom);
      end
      issue(1, 2, 0, 32'h3f8, $urandom);
      issue(1, 2, 0, 32'h3fc, $urandom);
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         if ($urandom_range(0, 3) == 0) a = 32'h3f8 + $urandom_range(0, 15);
         else a = 32'($urandom_range(0, 63));
         issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), a, $urandom);
         if ($urandom_range(0, 4) == 0) idle(1);
      end
      idle(RL + 3);
      check("queue_drained", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
